echo_stream_n: RTL and testbench
================================

Name: echo_stream_n

Overview:
Parametrised successor to the single-entry echo block. Accepts tagged echo requests into a DEPTH-entry FIFO. A response FSM drains the FIFO and emits each request as 1..16 indication beats: incrementing values, sequence-numbered, with full ready/valid back-pressure on the indication side. Sits between the request-method wrapper and the indication serializer.

Parameters:
WIDTH, 32, data width of echo value
DEPTH, 4, FIFO entries; power of two, >=2
TAGW, 2, channel tag width (up to 2^TAGW logical requesters)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
echoReq__ENA  input  1  request strobe; legal only while echoReq__RDY=1
echoReq_v  input  WIDTH  echo value
echoReq_tag  input  TAGW  channel tag, returned unchanged
echoReq_rpt  input  4  extra beats; total beats = rpt+1
echoReq__RDY  output  1  FIFO not full
ind_echo__ENA  output  1  indication beat valid
ind_echo_v  output  WIDTH  beat value
ind_echo_tag  output  TAGW  tag of originating request
ind_echo_seq  output  4  beat index within request, 0..rpt
ind_echo_last  output  1  final beat of request
ind_echo__RDY  input  1  consumer accepts beat
occupancy  output  clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset: async on nRST low. Clears FIFO pointers and occupancy; FSM to IDLE. ind_echo__ENA, _v, _tag, _seq, _last go 0; echoReq__RDY goes 1 after release. A beat in flight at reset is lost.
- Enqueue: echoReq__ENA=1 at a rising edge writes {v,tag,rpt} at the tail.
  - echoReq__RDY = (occupancy < DEPTH), combinational from registers.
  - ENA while RDY=0 is a protocol violation: bench asserts; RTL ignores the write.
- FSM states:
  - IDLE: ind_echo__ENA=0. If occupancy>0, pop head and load the output register at the next edge (seq=0). Go to EMIT.
  - EMIT: ind_echo__ENA=1. Outputs hold stable while ind_echo__RDY=0.
  - On an accepted beat (ENA&RDY at an edge) with seq<rpt: seq+1, v+1 (wraps mod 2^WIDTH), tag held.
  - On an accepted beat with seq==rpt (ind_echo_last=1):
    - occupancy>0 (counted before any same-edge enqueue): pop the next head and load it the same edge, so beats are back-to-back with no bubble.
    - otherwise: go to IDLE.
- Latency: request in cycle t gives first beat visible in cycle t+2 when the FSM is idle and the FIFO is empty. Enqueue is not bypassed into the output register.
- Same-edge enqueue and pop: both occur; occupancy unchanged. Allowed at any occupancy where RDY=1. At full, RDY=0 so only the pop occurs.
- Pointers wrap mod DEPTH. Occupancy ranges 0..DEPTH.
- ind_echo_last = (seq == stored rpt).
- Ordering is strictly FIFO, regardless of tag.

Optional Feature:
ECHO_STATS_EN:
- Defined: adds outputs stat_req[31:0] (requests accepted) and stat_beat[31:0] (beats accepted by consumer). Both are cleared by nRST and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package echo_stream_pkg: FSM state enum {IDLE, EMIT}; entry struct {v, tag, rpt}; localparam for occupancy width.
- Sub-module echo_store: DEPTH-entry circular buffer with push/pop/occupancy/full/empty. echo_stream_n holds the FSM and output register.

Test Plan:
- Reset then single request v=0x10, tag=1, rpt=0, consumer always ready -> one beat (v=0x10, tag=1, seq=0, last=1) two cycles after request; then ENA=0.
- Request v=0xFFFFFFFE, rpt=3 -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; seq 0..3; last only on seq 3 (wrap check).
- Four requests back-to-back with consumer ready=0 -> occupancy 3 after the fourth write (one entry popped into the output register). Fifth request lands (occupancy 4), then RDY=0. Release ready -> all five emitted in order with no idle cycle between requests.
- Consumer toggling ready every cycle during an rpt=2 request -> each beat value held while ready=0; exactly 3 beats accepted.
- Simultaneous enqueue with last-beat pop at occupancy 2 -> occupancy stays 2; next head loaded with no bubble.
- nRST asserted mid-EMIT (seq=1 of rpt=3) -> ind_echo__ENA drops immediately without a clock; occupancy 0; first request after release emits normally. With ECHO_STATS_EN, stat_req and stat_beat read 0.

Source files
------------

// File: rtl/echo_stream_pkg.sv
// Shared definitions for the echo_stream_n request/indication block.
// Build option: ECHO_STATS_EN adds request/beat statistics counters.
package echo_stream_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_EMIT = 1'b1;

    localparam int RPT_W = 4;
    localparam int STAT_W = 32;

    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/echo_store.sv
// Circular buffer of echo request entries with occupancy tracking.
// Pushes while full and pops while empty are dropped.
module echo_store
    import echo_stream_pkg::*;
#(
    parameter int EW    = 38,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [EW-1:0]            din,
    input  logic                     pop,
    output logic [EW-1:0]            dout,
    output logic [occ_w(DEPTH)-1:0]  occ,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = occ_w(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (occ_q == OW'(DEPTH));
    assign empty = (occ_q == '0);
    assign occ   = occ_q;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_q] = din;
        end
        // DEPTH is a power of two, so pointers wrap naturally
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        occ_d = occ_q + OW'(do_push) - OW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/echo_stream_n.sv
// Queued echo block: FIFO of tagged requests replayed as incrementing beats.
// Build option: ECHO_STATS_EN adds stat_req / stat_beat counters.
module echo_stream_n
    import echo_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     echoReq__ENA,
    input  logic [WIDTH-1:0]         echoReq_v,
    input  logic [TAGW-1:0]          echoReq_tag,
    input  logic [RPT_W-1:0]         echoReq_rpt,
    output logic                     echoReq__RDY,
    output logic                     ind_echo__ENA,
    output logic [WIDTH-1:0]         ind_echo_v,
    output logic [TAGW-1:0]          ind_echo_tag,
    output logic [RPT_W-1:0]         ind_echo_seq,
    output logic                     ind_echo_last,
    input  logic                     ind_echo__RDY,
`ifdef ECHO_STATS_EN
    output logic [STAT_W-1:0]        stat_req,
    output logic [STAT_W-1:0]        stat_beat,
`endif
    output logic [occ_w(DEPTH)-1:0]  occupancy
);

    typedef struct packed {
        logic [WIDTH-1:0] v;
        logic [TAGW-1:0]  tag;
        logic [RPT_W-1:0] rpt;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t           wr_entry;
    entry_t           head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             emit;
    logic             accept;
    logic             at_last;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic [RPT_W-1:0] seq_q, seq_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;

    assign wr_entry = '{v: echoReq_v, tag: echoReq_tag, rpt: echoReq_rpt};
    assign push     = echoReq__ENA & ~full;

    echo_store #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .occ   (occupancy),
        .full  (full),
        .empty (empty)
    );

    assign emit    = (state_q == ST_EMIT);
    assign at_last = (seq_q == rpt_q);
    assign accept  = emit & ind_echo__RDY;

    assign echoReq__RDY  = ~full;
    assign ind_echo__ENA = emit;
    assign ind_echo_v    = v_q;
    assign ind_echo_tag  = tag_q;
    assign ind_echo_seq  = seq_q;
    assign ind_echo_last = emit & at_last;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        tag_d   = tag_q;
        seq_d   = seq_q;
        rpt_d   = rpt_q;
        pop     = 1'b0;
        // empty reflects the count before any same-edge push
        if (!emit || (accept && at_last)) begin
            if (!empty) begin
                pop     = 1'b1;
                state_d = ST_EMIT;
                v_d     = head.v;
                tag_d   = head.tag;
                rpt_d   = head.rpt;
                seq_d   = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (accept) begin
            seq_d = seq_q + 1'b1;
            v_d   = v_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            v_q     <= '0;
            tag_q   <= '0;
            seq_q   <= '0;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            tag_q   <= tag_d;
            seq_q   <= seq_d;
            rpt_q   <= rpt_d;
        end
    end

`ifdef ECHO_STATS_EN
    logic [STAT_W-1:0] stat_req_q, stat_req_d;
    logic [STAT_W-1:0] stat_beat_q, stat_beat_d;

    always_comb begin
        stat_req_d  = stat_req_q + STAT_W'(push);
        stat_beat_d = stat_beat_q + STAT_W'(accept);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_req_q  <= '0;
            stat_beat_q <= '0;
        end else begin
            stat_req_q  <= stat_req_d;
            stat_beat_q <= stat_beat_d;
        end
    end

    assign stat_req  = stat_req_q;
    assign stat_beat = stat_beat_q;
`endif

endmodule

// File: tb/tb_echo_stream_n.sv
// Directed vector bench for echo_stream_n (default parameters).
// Build option: ECHO_STATS_EN also checks the statistics counters.
module tb_echo_stream_n;

    logic        clk;
    logic        rst_n;
    logic        req_ena;
    logic [31:0] req_v;
    logic [1:0]  req_tag;
    logic [3:0]  req_rpt;
    logic        req_rdy;
    logic        ind_ena;
    logic [31:0] ind_v;
    logic [1:0]  ind_tag;
    logic [3:0]  ind_seq;
    logic        ind_last;
    logic        ind_rdy;
    logic [2:0]  occ;
`ifdef ECHO_STATS_EN
    logic [31:0] stat_req;
    logic [31:0] stat_beat;
`endif

    int checks;
    int errors;

    echo_stream_n #(
        .WIDTH (32),
        .DEPTH (4),
        .TAGW  (2)
    ) dut (
        .CLK           (clk),
        .nRST          (rst_n),
        .echoReq__ENA  (req_ena),
        .echoReq_v     (req_v),
        .echoReq_tag   (req_tag),
        .echoReq_rpt   (req_rpt),
        .echoReq__RDY  (req_rdy),
        .ind_echo__ENA (ind_ena),
        .ind_echo_v    (ind_v),
        .ind_echo_tag  (ind_tag),
        .ind_echo_seq  (ind_seq),
        .ind_echo_last (ind_last),
        .ind_echo__RDY (ind_rdy),
`ifdef ECHO_STATS_EN
        .stat_req      (stat_req),
        .stat_beat     (stat_beat),
`endif
        .occupancy     (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic [31:0] v;
        logic [1:0]  tag;
        logic [3:0]  rpt;
        logic        ir;
        logic        e_ena;
        logic [31:0] e_v;
        logic [1:0]  e_tag;
        logic [3:0]  e_seq;
        logic        e_last;
        logic [2:0]  e_occ;
        logic        e_rdy;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic ena, input logic [31:0] v, input logic [1:0] tag,
        input logic [3:0] rpt, input logic ir,
        input logic e_ena, input logic [31:0] e_v, input logic [1:0] e_tag,
        input logic [3:0] e_seq, input logic e_last,
        input logic [2:0] e_occ, input logic e_rdy);
        vec_t r;
        r.ena = ena; r.v = v; r.tag = tag; r.rpt = rpt; r.ir = ir;
        r.e_ena = e_ena; r.e_v = e_v; r.e_tag = e_tag; r.e_seq = e_seq;
        r.e_last = e_last; r.e_occ = e_occ; r.e_rdy = e_rdy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requests must only be issued while the FIFO has room
    always @(posedge clk) begin
        if (rst_n && req_ena) begin
            checks++;
            if (!req_rdy) begin
                errors++;
                $display("FAIL proto: echoReq__ENA while RDY=0 at %0t", $time);
            end
        end
    end

    int accepted;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        req_ena = 1'b0;
        req_v   = '0;
        req_tag = '0;
        req_rpt = '0;
        ind_rdy = 1'b1;

        // ena v tag rpt ir | ena v tag seq last occ rdy
        vecs[0]  = mk(1, 32'h10, 1, 0, 1,  0, 0, 0, 0, 0, 1, 1);
        vecs[1]  = mk(0, 0, 0, 0, 1,  1, 32'h10, 1, 0, 1, 0, 1);
        vecs[2]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(1, 32'hFFFF_FFFE, 2, 3, 1,  0, 0, 0, 0, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 0, 1,  1, 32'hFFFF_FFFE, 2, 0, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 0, 1,  1, 32'hFFFF_FFFF, 2, 1, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0, 1,  1, 32'h0, 2, 2, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 1,  1, 32'h1, 2, 3, 1, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1);
        vecs[9]  = mk(1, 32'h100, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
        vecs[10] = mk(1, 32'h200, 1, 1, 0,  1, 32'h100, 0, 0, 1, 1, 1);
        vecs[11] = mk(1, 32'h300, 2, 0, 0,  1, 32'h100, 0, 0, 1, 2, 1);
        vecs[12] = mk(1, 32'h400, 3, 0, 0,  1, 32'h100, 0, 0, 1, 3, 1);
        vecs[13] = mk(1, 32'h500, 0, 0, 0,  1, 32'h100, 0, 0, 1, 4, 0);
        vecs[14] = mk(0, 0, 0, 0, 1,  1, 32'h200, 1, 0, 0, 3, 1);
        vecs[15] = mk(0, 0, 0, 0, 1,  1, 32'h201, 1, 1, 1, 3, 1);
        vecs[16] = mk(0, 0, 0, 0, 1,  1, 32'h300, 2, 0, 1, 2, 1);
        vecs[17] = mk(0, 0, 0, 0, 1,  1, 32'h400, 3, 0, 1, 1, 1);
        vecs[18] = mk(0, 0, 0, 0, 1,  1, 32'h500, 0, 0, 1, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1);
        vecs[20] = mk(1, 32'h600, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
        vecs[21] = mk(1, 32'h700, 2, 0, 0,  1, 32'h600, 1, 0, 1, 1, 1);
        vecs[22] = mk(1, 32'h800, 3, 0, 0,  1, 32'h600, 1, 0, 1, 2, 1);
        vecs[23] = mk(1, 32'h900, 0, 0, 1,  1, 32'h700, 2, 0, 1, 2, 1);
        vecs[24] = mk(0, 0, 0, 0, 1,  1, 32'h800, 3, 0, 1, 1, 1);
        vecs[25] = mk(0, 0, 0, 0, 1,  1, 32'h900, 0, 0, 1, 0, 1);
        vecs[26] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1);

        #2;
        chk("rst_ena", 32'(ind_ena), 0);
        chk("rst_v", ind_v, 0);
        chk("rst_tag", 32'(ind_tag), 0);
        chk("rst_seq", 32'(ind_seq), 0);
        chk("rst_last", 32'(ind_last), 0);
        chk("rst_occ", 32'(occ), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_rdy", 32'(req_rdy), 1);
        chk("rel_ena", 32'(ind_ena), 0);
`ifdef ECHO_STATS_EN
        chk("rst_stat_req", stat_req, 0);
        chk("rst_stat_beat", stat_beat, 0);
`endif

        for (int i = 0; i < NV; i++) begin
            req_ena = vecs[i].ena;
            req_v   = vecs[i].v;
            req_tag = vecs[i].tag;
            req_rpt = vecs[i].rpt;
            ind_rdy = vecs[i].ir;
            step();
            chk($sformatf("v%0d_ena", i), 32'(ind_ena), 32'(vecs[i].e_ena));
            chk($sformatf("v%0d_occ", i), 32'(occ), 32'(vecs[i].e_occ));
            chk($sformatf("v%0d_rdy", i), 32'(req_rdy), 32'(vecs[i].e_rdy));
            if (vecs[i].e_ena) begin
                chk($sformatf("v%0d_v", i), ind_v, vecs[i].e_v);
                chk($sformatf("v%0d_tag", i), 32'(ind_tag), 32'(vecs[i].e_tag));
                chk($sformatf("v%0d_seq", i), 32'(ind_seq), 32'(vecs[i].e_seq));
                chk($sformatf("v%0d_last", i), 32'(ind_last), 32'(vecs[i].e_last));
            end
        end
        req_ena = 1'b0;

`ifdef ECHO_STATS_EN
        // 1 + 1 + 5 + 4 requests; 1 + 4 + 6 + 4 beats
        chk("stat_req", stat_req, 11);
        chk("stat_beat", stat_beat, 15);
`endif

        // Consumer toggles ready every cycle during an rpt=2 request
        ind_rdy = 1'b0;
        req_ena = 1'b1;
        req_v   = 32'hA0;
        req_tag = 2'd1;
        req_rpt = 4'd2;
        step();
        req_ena = 1'b0;
        step();
        chk("tog_start", 32'(ind_ena), 1);
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            ind_rdy = (c % 2) == 1;
            if (ind_ena) begin
                chk("tog_v", ind_v, 32'hA0 + 32'(accepted));
                chk("tog_seq", 32'(ind_seq), 32'(accepted));
                chk("tog_last", 32'(ind_last), 32'(accepted == 2));
                chk("tog_tag", 32'(ind_tag), 1);
            end
            if (ind_ena && ind_rdy) accepted++;
            step();
        end
        chk("tog_count", 32'(accepted), 3);
        chk("tog_idle", 32'(ind_ena), 0);

        // Reset during EMIT with a second request still queued
        ind_rdy = 1'b0;
        req_ena = 1'b1;
        req_v   = 32'hB0;
        req_tag = 2'd3;
        req_rpt = 4'd3;
        step();
        req_v   = 32'hD0;
        req_rpt = 4'd0;
        step();
        req_ena = 1'b0;
        ind_rdy = 1'b1;
        step();
        chk("mid_seq", 32'(ind_seq), 1);
        chk("mid_v", ind_v, 32'hB1);
        chk("mid_occ", 32'(occ), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ena", 32'(ind_ena), 0);
        chk("arst_occ", 32'(occ), 0);
        chk("arst_v", ind_v, 0);
        chk("arst_seq", 32'(ind_seq), 0);
        chk("arst_last", 32'(ind_last), 0);
`ifdef ECHO_STATS_EN
        chk("arst_stat_req", stat_req, 0);
        chk("arst_stat_beat", stat_beat, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rdy", 32'(req_rdy), 1);
        chk("post_ena", 32'(ind_ena), 0);
        req_ena = 1'b1;
        req_v   = 32'hC0;
        req_tag = 2'd2;
        req_rpt = 4'd0;
        step();
        req_ena = 1'b0;
        chk("post_q_ena", 32'(ind_ena), 0);
        step();
        chk("post_ena1", 32'(ind_ena), 1);
        chk("post_v", ind_v, 32'hC0);
        chk("post_tag", 32'(ind_tag), 2);
        chk("post_last", 32'(ind_last), 1);
        step();
        chk("post_done", 32'(ind_ena), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
